// File: rtl/gate_response_checker_if.sv
// Bundle of stimulus-side and result-side signals for gate_response_checker.
// The master modport is the driving side: start/func_sel, the applied vector
// and the DUT output under check. The slave modport is the checker itself.
// ERR_W must match the ERR_W of the checker this interface connects to.
interface gate_response_checker_if #(
    parameter int ERR_W = 4
);
    logic             start;
    logic [1:0]       func_sel;
    logic             vec_valid;
    logic             a;
    logic             b;
    logic             dut_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_cnt;
    logic [3:0]       coverage;
    logic [7:0]       sample_cnt;
    logic [2:0]       first_fail;

    modport master (
        output start, func_sel, vec_valid, a, b, dut_out,
        input  busy, done, pass, err_cnt, coverage, sample_cnt, first_fail
    );

    modport slave (
        input  start, func_sel, vec_valid, a, b, dut_out,
        output busy, done, pass, err_cnt, coverage, sample_cnt, first_fail
    );
endinterface

// File: rtl/gate_response_checker.sv
// Response monitor for 2-input gate labs. Each accepted vector (a, b) is
// latched, the checker waits SETTLE_CYCLES clocks, samples dut_out and compares
// it against the reference gate chosen at start (00 AND, 01 OR, 10 XOR,
// 11 NAND). It tracks a saturating mismatch count, truth-table coverage and the
// number of compares; the run ends on full coverage or after MAX_SAMPLES.
// Optional build macro GATE_CHECKER_FIRST_FAIL_EN: when defined, first_fail
// holds {a, b, dut_out} of the first mismatch after start; otherwise it is 0.
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 5,   // 1..255
    parameter int MAX_SAMPLES   = 16,  // 1..255
    parameter int ERR_W         = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    gate_response_checker_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_SETTLE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_func;
    logic             r_a;
    logic             r_b;
    logic [7:0]       r_settle;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_cov;
    logic [7:0]       r_samples;

    logic             w_expected;
    logic             w_mismatch;
    logic [3:0]       w_cov_upd;
    logic [8:0]       w_samples_inc;
    logic             w_finish;

    // Reference gate selected by the latched function code.
    function automatic logic ref_gate(input logic [1:0] f, input logic x, input logic y);
        case (f)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x ^ y;
            default: return ~(x & y);
        endcase
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

    assign w_expected    = ref_gate(r_func, r_a, r_b);
    assign w_mismatch    = (bus.dut_out != w_expected);
    assign w_cov_upd     = r_cov | (4'b0001 << {r_a, r_b});
    assign w_samples_inc = {1'b0, r_samples} + 9'd1;
    // Completion test uses the coverage and count as they will be after this compare.
    assign w_finish      = (w_cov_upd == 4'hF) || (w_samples_inc == 9'(MAX_SAMPLES));

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start overrides every other input in every state.
    always_comb begin
        w_next = r_state;
        if (bus.start) begin
            w_next = S_ARMED;
        end else begin
            case (r_state)
                S_ARMED:   if (bus.vec_valid) w_next = S_SETTLE;
                S_SETTLE:  if (r_settle == 8'd0) w_next = S_COMPARE;
                S_COMPARE: w_next = w_finish ? S_DONE : S_ARMED;
                default:   w_next = r_state;
            endcase
        end
    end

    // Vector latch, settle counter and run statistics.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_func    <= 2'b00;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_settle  <= 8'd0;
            r_err     <= '0;
            r_cov     <= 4'h0;
            r_samples <= 8'd0;
        end else if (bus.start) begin
            r_func    <= bus.func_sel;
            r_err     <= '0;
            r_cov     <= 4'h0;
            r_samples <= 8'd0;
        end else begin
            case (r_state)
                S_ARMED: begin
                    if (bus.vec_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_settle <= 8'(SETTLE_CYCLES - 1);
                    end
                end
                S_SETTLE: begin
                    if (r_settle != 8'd0) r_settle <= r_settle - 8'd1;
                end
                S_COMPARE: begin
                    if (w_mismatch) r_err <= sat_inc(r_err);
                    r_cov     <= w_cov_upd;
                    r_samples <= w_samples_inc[7:0];
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_CHECKER_FIRST_FAIL_EN
    logic [2:0] r_first_fail;
    logic       r_ff_captured;

    // Capture the first mismatch of a run; later mismatches leave it alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_first_fail  <= 3'b000;
            r_ff_captured <= 1'b0;
        end else if (bus.start) begin
            r_first_fail  <= 3'b000;
            r_ff_captured <= 1'b0;
        end else if (r_state == S_COMPARE && w_mismatch && !r_ff_captured) begin
            r_first_fail  <= {r_a, r_b, bus.dut_out};
            r_ff_captured <= 1'b1;
        end
    end

    assign bus.first_fail = r_first_fail;
`else
    assign bus.first_fail = 3'b000;
`endif

    assign bus.busy       = (r_state == S_SETTLE) || (r_state == S_COMPARE);
    assign bus.done       = (r_state == S_DONE);
    assign bus.pass       = (r_state == S_DONE) && (r_err == '0) && (r_cov == 4'hF);
    assign bus.err_cnt    = r_err;
    assign bus.coverage   = r_cov;
    assign bus.sample_cnt = r_samples;

endmodule

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker. Two checkers (ERR_W=4 and ERR_W=2)
// see identical stimulus so counter saturation can be observed at both widths.
module tb_gate_response_checker;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] func_sel = 2'b00;
    logic       vec_valid = 1'b0;
    logic       a = 1'b0;
    logic       b = 1'b0;
    logic       dut_out = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef GATE_CHECKER_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    gate_response_checker_if #(.ERR_W(4)) if4 ();
    gate_response_checker_if #(.ERR_W(2)) if2 ();

    assign if4.start = start;  assign if2.start = start;
    assign if4.func_sel = func_sel;  assign if2.func_sel = func_sel;
    assign if4.vec_valid = vec_valid;  assign if2.vec_valid = vec_valid;
    assign if4.a = a;  assign if2.a = a;
    assign if4.b = b;  assign if2.b = b;
    assign if4.dut_out = dut_out;  assign if2.dut_out = dut_out;

    gate_response_checker #(.SETTLE_CYCLES(5), .MAX_SAMPLES(16), .ERR_W(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(if4.slave));
    gate_response_checker #(.SETTLE_CYCLES(5), .MAX_SAMPLES(16), .ERR_W(2)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .bus(if2.slave));

    always #5 clk = ~clk;

    // Truth tables indexed by {a,b}: bit 3 = 11, bit 0 = 00.
    function automatic logic golden(input logic [1:0] f, input logic x, input logic y);
        logic [3:0] tt;
        case (f)
            2'b00:   tt = 4'b1000;
            2'b01:   tt = 4'b1110;
            2'b10:   tt = 4'b0110;
            default: tt = 4'b0111;
        endcase
        return tt[{x, y}];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] f);
        start = 1'b1;
        func_sel = f;
        tick();
        start = 1'b0;
    endtask

    // Present one vector with the given DUT response and wait for the compare to finish.
    task automatic apply(input logic va, input logic vb, input logic out);
        a = va;
        b = vb;
        dut_out = out;
        vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        for (int i = 0; i < 50 && if4.busy; i++) tick();
        check("busy_wait", {31'd0, if4.busy}, 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        check("rst_busy", {31'd0, if4.busy}, 32'd0);
        check("rst_done", {31'd0, if4.done}, 32'd0);
        check("rst_pass", {31'd0, if4.pass}, 32'd0);
        check("rst_err", {28'd0, if4.err_cnt}, 32'd0);
        check("rst_cov", {28'd0, if4.coverage}, 32'd0);
        check("rst_samples", {24'd0, if4.sample_cnt}, 32'd0);
        check("rst_ff", {29'd0, if4.first_fail}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Correct AND DUT over the full truth table
        pulse_start(2'b00);
        check("t1_armed_busy", {31'd0, if4.busy}, 32'd0);
        check("t1_armed_done", {31'd0, if4.done}, 32'd0);
        apply(1'b0, 1'b0, 1'b0);
        check("t1_cov_after1", {28'd0, if4.coverage}, 32'h1);
        check("t1_samples_after1", {24'd0, if4.sample_cnt}, 32'd1);
        check("t1_done_after1", {31'd0, if4.done}, 32'd0);
        apply(1'b0, 1'b1, 1'b0);
        apply(1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 1'b1);
        check("t1_done", {31'd0, if4.done}, 32'd1);
        check("t1_err", {28'd0, if4.err_cnt}, 32'd0);
        check("t1_cov", {28'd0, if4.coverage}, 32'hF);
        check("t1_samples", {24'd0, if4.sample_cnt}, 32'd4);
        check("t1_pass", {31'd0, if4.pass}, 32'd1);

        // vec_valid in DONE is ignored
        a = 1'b0; b = 1'b0; dut_out = 1'b1; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("done_ignore_samples", {24'd0, if4.sample_cnt}, 32'd4);
        check("done_ignore_err", {28'd0, if4.err_cnt}, 32'd0);
        check("done_hold", {31'd0, if4.done}, 32'd1);

        // AND reference, DUT behaves as OR: vectors 01 and 10 mismatch
        pulse_start(2'b00);
        check("t2_clr_err", {28'd0, if4.err_cnt}, 32'd0);
        check("t2_clr_cov", {28'd0, if4.coverage}, 32'd0);
        check("t2_clr_samples", {24'd0, if4.sample_cnt}, 32'd0);
        check("t2_clr_done", {31'd0, if4.done}, 32'd0);
        apply(1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 1'b1);
        apply(1'b1, 1'b0, 1'b1);
        apply(1'b1, 1'b1, 1'b1);
        check("t2_done", {31'd0, if4.done}, 32'd1);
        check("t2_err4", {28'd0, if4.err_cnt}, 32'd2);
        check("t2_err2", {30'd0, if2.err_cnt}, 32'd2);
        check("t2_pass", {31'd0, if4.pass}, 32'd0);
        check("t2_ff", {29'd0, if4.first_fail}, FF_EN ? 32'h3 : 32'h0);

        // OR, XOR, NAND references with a correct DUT; func_sel changed after start
        for (int f = 1; f < 4; f++) begin
            pulse_start(2'(f));
            func_sel = 2'(f) ^ 2'b11;
            for (int v = 0; v < 4; v++) begin
                logic [1:0] vv;
                vv = 2'(v);
                apply(vv[1], vv[0], golden(2'(f), vv[1], vv[0]));
            end
            check($sformatf("func%0d_pass", f), {31'd0, if4.pass}, 32'd1);
            check($sformatf("func%0d_err", f), {28'd0, if4.err_cnt}, 32'd0);
        end

        // Vector 11 repeated: run ends on MAX_SAMPLES
        pulse_start(2'b00);
        for (int i = 0; i < 15; i++) apply(1'b1, 1'b1, 1'b1);
        check("t3_done_at15", {31'd0, if4.done}, 32'd0);
        apply(1'b1, 1'b1, 1'b1);
        check("t3_done", {31'd0, if4.done}, 32'd1);
        check("t3_samples", {24'd0, if4.sample_cnt}, 32'd16);
        check("t3_cov", {28'd0, if4.coverage}, 32'h8);
        check("t3_pass", {31'd0, if4.pass}, 32'd0);

        // Second vec_valid two cycles after the first is dropped; result at cycle 6
        pulse_start(2'b00);
        a = 1'b0; b = 1'b0; dut_out = 1'b0;
        vec_valid = 1'b1;
        tick();                 // edge 0 accepts the vector
        vec_valid = 1'b0;
        tick();                 // edge 1
        vec_valid = 1'b1;
        tick();                 // edge 2: dropped
        vec_valid = 1'b0;
        tick(); tick(); tick(); // edges 3..5
        check("t4_samples_c5", {24'd0, if4.sample_cnt}, 32'd0);
        check("t4_busy_c5", {31'd0, if4.busy}, 32'd1);
        tick();                 // edge 6
        check("t4_samples_c6", {24'd0, if4.sample_cnt}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        check("t4_samples_later", {24'd0, if4.sample_cnt}, 32'd1);
        check("t4_busy_later", {31'd0, if4.busy}, 32'd0);

        // start coinciding with vec_valid drops the vector
        start = 1'b1; func_sel = 2'b00; vec_valid = 1'b1;
        tick();
        start = 1'b0; vec_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("start_vv_samples", {24'd0, if4.sample_cnt}, 32'd0);
        check("start_vv_busy", {31'd0, if4.busy}, 32'd0);

        // Stuck-at-1 DUT: error counters saturate without wrapping
        pulse_start(2'b00);
        for (int i = 0; i < 16; i++) begin
            logic [1:0] vv;
            vv = 2'(i % 3);
            apply(vv[1], vv[0], 1'b1);
            if (i == 2) check("t5_err2_at3", {30'd0, if2.err_cnt}, 32'd3);
            if (i == 4) check("t5_err2_at5", {30'd0, if2.err_cnt}, 32'd3);
        end
        check("t5_err2", {30'd0, if2.err_cnt}, 32'd3);
        check("t5_err4", {28'd0, if4.err_cnt}, 32'd15);
        check("t5_samples", {24'd0, if4.sample_cnt}, 32'd16);
        check("t5_cov", {28'd0, if4.coverage}, 32'h7);
        check("t5_done", {31'd0, if4.done}, 32'd1);
        check("t5_pass", {31'd0, if4.pass}, 32'd0);
        check("t5_ff", {29'd0, if4.first_fail}, FF_EN ? 32'h1 : 32'h0);

        // Asynchronous reset during SETTLE
        pulse_start(2'b00);
        apply(1'b0, 1'b0, 1'b1);
        a = 1'b1; b = 1'b1; dut_out = 1'b1; vec_valid = 1'b1;
        tick();
        vec_valid = 1'b0;
        tick();
        check("t6_busy_pre", {31'd0, if4.busy}, 32'd1);
        check("t6_samples_pre", {24'd0, if4.sample_cnt}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_busy_rst", {31'd0, if4.busy}, 32'd0);
        check("t6_samples_rst", {24'd0, if4.sample_cnt}, 32'd0);
        check("t6_err_rst", {28'd0, if4.err_cnt}, 32'd0);
        check("t6_cov_rst", {28'd0, if4.coverage}, 32'd0);
        check("t6_ff_rst", {29'd0, if4.first_fail}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        pulse_start(2'b00);
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            apply(vv[1], vv[0], golden(2'b00, vv[1], vv[0]));
        end
        check("t6_rearm_pass", {31'd0, if4.pass}, 32'd1);
        check("t6_rearm_samples", {24'd0, if4.sample_cnt}, 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
